mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the LoongArch scalar core. It sits between EX and WB and is the transmitter on the MEM→WB valid/ready interface.
- It latches the EX result and waits for the data-SRAM response on loads. It sign- or zero-extends load data, then presents the writeback bundle to WB.
- It holds returned load data locally when WB back-pressures, so no response is lost.

Parameters:
- DW, 32, datapath/register width
- AW, 5, register-file address width

Ports:
- clk  in  1  core clock, all logic posedge
- rst  in  1  synchronous reset, active-low (0 = reset)
- ex_to_mem_valid  in  1  EX bundle valid
- o_mem_ready  out  1  MEM can accept EX bundle this cycle
- ex_to_mem_pc  in  32  instruction PC
- ex_to_mem_inst  in  32  instruction word
- ex_to_mem_alu_result  in  DW  ALU result / load address
- ex_to_mem_rf_waddr  in  AW  destination register
- ex_to_mem_rf_we  in  1  register write enable
- ex_to_mem_load_op  in  3  load type (LOAD_* encoding), 0 = not a load
- data_sram_data_ok  in  1  load response valid (1-cycle pulse, one per load request issued by EX)
- data_sram_rdata  in  32  load response word
- i_wb_ready  in  1  WB can accept
- mem_to_wb_valid  out  1  bundle to WB valid
- mem_to_wb_rf_wdata  out  DW  writeback data
- mem_to_wb_rf_waddr  out  AW  writeback address
- mem_to_wb_rf_we  out  1  writeback enable
- mem_to_wb_pc  out  32  PC
- mem_to_wb_inst  out  32  instruction
- mem_load_pending  out  1  valid load in MEM without data yet (load-use stall for ID)

Behaviour:
- Reset (rst=0 at posedge):
  - mem_valid=0, state=M_IDLE, all payload and hold registers=0.
  - All outputs are 0 except o_mem_ready=1.
- Handshake:
  - mem_ready_go = !is_load | (state==M_HOLD) | data_sram_data_ok.
  - o_mem_ready = !mem_valid | (mem_ready_go & i_wb_ready).
  - mem_to_wb_valid = mem_valid & mem_ready_go.
- Acceptance:
  - If o_mem_ready, then mem_valid <= ex_to_mem_valid.
  - Payload is captured only when ex_to_mem_valid & o_mem_ready.
  - Back-to-back transfers are supported: one instruction per cycle, zero bubbles for non-loads.
- Latency:
  - Non-load: presented to WB the cycle after acceptance.
  - Load: presented in the data_ok cycle at the earliest, combinationally from data_sram_rdata.
- FSM:
  - M_IDLE:
    - Loaded bundle is a valid load → M_WAIT.
    - Otherwise stays in M_IDLE.
  - M_WAIT:
    - data_ok & i_wb_ready: bundle leaves. Go to M_WAIT if a new load is accepted the same cycle, else M_IDLE.
    - data_ok & !i_wb_ready: rdata goes into hold_data → M_HOLD.
    - No data_ok: stay in M_WAIT.
  - M_HOLD:
    - Output is taken from hold_data.
    - When i_wb_ready: go to M_WAIT if a new load is accepted, else M_IDLE.
- data_ok while state==M_IDLE (e.g. a response arriving after reset) is ignored.
- mem_load_pending = mem_valid & is_load & (state!=M_HOLD) & !data_sram_data_ok.
- Load extension: byte offset a=alu_result[1:0]; raw=(state==M_HOLD)?hold_data:data_sram_rdata.
  - LD.B: sign-extends raw byte a.
  - LD.BU: zero-extends raw byte a.
  - LD.H: sign-extends halfword a[1].
  - LD.HU: zero-extends halfword a[1].
  - LD.W: raw.
  - Non-load: alu_result.
- Misaligned addresses are not detected; the low bits are used as above.
- Output gating:
  - mem_to_wb_rf_we and mem_to_wb_rf_waddr are forced to 0 when !mem_valid.
  - Other payload outputs pass through unmodified.

Optional Feature:
- MEM_FWD_EN defined:
  - Adds outputs mem_fwd_valid (1), mem_fwd_waddr (AW), mem_fwd_wdata (DW) for an ID bypass.
  - mem_fwd_valid = mem_valid & rf_we & mem_ready_go & (rf_waddr!=0).
  - mem_fwd_wdata equals mem_to_wb_rf_wdata.
- Undefined: these ports and logic are absent; ID relies on WB-stage bypass and mem_load_pending stalls only.

Decomposition:
- Package core_pkg:
  - LOAD_NONE=3'b000, LOAD_B=3'b001, LOAD_H=3'b010, LOAD_W=3'b011, LOAD_BU=3'b101, LOAD_HU=3'b110.
  - MEM FSM state encodings M_IDLE/M_WAIT/M_HOLD.
- Sub-module load_ext: a combinational extender, inputs raw[31:0], load_op, addr[1:0]; output data[31:0].

Test Plan:
- Reset: rst=0 for 2 cycles mid-M_WAIT → mem_to_wb_valid=0, o_mem_ready=1, mem_to_wb_rf_we=0. A later data_ok is ignored and no bundle is produced.
- Non-load stream: 4 back-to-back ALU bundles (waddr 1..4, result 0x11..0x44) with wb_ready=1 → 4 consecutive mem_to_wb_valid cycles with matching data and no bubbles.
- LD.B at address 0x1003, rdata=0x80FF_1234, data_ok 3 cycles after acceptance:
  - mem_load_pending=1 for 3 cycles.
  - Then wdata=0xFFFF_FF80 in the data_ok cycle.
  - LD.BU on the same stimulus gives 0x0000_0080.
- LD.HU at address 0x2002, rdata=0xBEEF_0001 → wdata=0x0000_BEEF. LD.H on the same stimulus gives 0xFFFF_BEEF.
- WB stall: data_ok arrives while wb_ready=0 for 2 cycles → state M_HOLD, o_mem_ready=0, mem_to_wb_valid held at 1. When wb_ready=1, the same LD.W data 0xCAFE_F00D is delivered exactly once.
- MEM_FWD_EN: ALU write to r5=0x77 → mem_fwd_valid=1, waddr=5, wdata=0x77. A write to r0 gives mem_fwd_valid=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the scalar core pipeline.
// Holds the load-type encodings produced by decode and the MEM-stage FSM states.
package core_pkg;

  localparam int unsigned LOAD_OP_W = 3;

  // Load type carried from EX; LOAD_NONE marks a non-load instruction.
  localparam logic [LOAD_OP_W-1:0] LOAD_NONE = 3'b000;
  localparam logic [LOAD_OP_W-1:0] LOAD_B    = 3'b001;
  localparam logic [LOAD_OP_W-1:0] LOAD_H    = 3'b010;
  localparam logic [LOAD_OP_W-1:0] LOAD_W    = 3'b011;
  localparam logic [LOAD_OP_W-1:0] LOAD_BU   = 3'b101;
  localparam logic [LOAD_OP_W-1:0] LOAD_HU   = 3'b110;

  // MEM stage: idle/ALU result, waiting for load data, holding load data under back-pressure.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_HOLD = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: combinational load-data extender.
// Ports:
//   raw     - 32-bit word returned by the data SRAM (or held copy)
//   load_op - load type (LOAD_* encoding)
//   addr    - low two bits of the load address (byte offset)
//   data    - extended result; unknown/word/non-load types return raw unchanged
import core_pkg::*;

module load_ext (
  input  logic [31:0]          raw,
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr,
  output logic [31:0]          data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select: byte by full offset, halfword by offset bit 1 (misalignment ignored).
  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Sign/zero extension by load type.
  always_comb begin
    data = raw;
    case (load_op)
      LOAD_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_BU: data = {24'd0, byte_sel};
      LOAD_H:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_HU: data = {16'd0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB (transmitter on MEM->WB valid/ready).
// Latches the EX bundle, waits for the data-SRAM response on loads, extends load data
// and presents the writeback bundle to WB. Load data that arrives while WB stalls is
// kept in a local hold register so no response is lost.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   ex_to_mem_*              - EX bundle in, o_mem_ready back to EX
//   data_sram_data_ok/rdata  - load response (one pulse per issued load)
//   i_wb_ready               - WB accept
//   mem_to_wb_*              - writeback bundle out
//   mem_load_pending         - valid load still waiting for data (ID load-use stall)
//   mem_fwd_valid/waddr/wdata- ID bypass, present only when MEM_FWD_EN is defined
import core_pkg::*;

module mem_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_to_mem_valid,
  output logic                 o_mem_ready,
  input  logic [31:0]          ex_to_mem_pc,
  input  logic [31:0]          ex_to_mem_inst,
  input  logic [DW-1:0]        ex_to_mem_alu_result,
  input  logic [AW-1:0]        ex_to_mem_rf_waddr,
  input  logic                 ex_to_mem_rf_we,
  input  logic [LOAD_OP_W-1:0] ex_to_mem_load_op,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 i_wb_ready,
  output logic                 mem_to_wb_valid,
  output logic [DW-1:0]        mem_to_wb_rf_wdata,
  output logic [AW-1:0]        mem_to_wb_rf_waddr,
  output logic                 mem_to_wb_rf_we,
  output logic [31:0]          mem_to_wb_pc,
  output logic [31:0]          mem_to_wb_inst,
  output logic                 mem_load_pending
`ifdef MEM_FWD_EN
  ,
  output logic                 mem_fwd_valid,
  output logic [AW-1:0]        mem_fwd_waddr,
  output logic [DW-1:0]        mem_fwd_wdata
`endif
);

  mem_state_e           state;
  logic                 mem_valid;
  logic [31:0]          pc_q;
  logic [31:0]          inst_q;
  logic [DW-1:0]        alu_q;
  logic [AW-1:0]        waddr_q;
  logic                 we_q;
  logic [LOAD_OP_W-1:0] op_q;
  logic [31:0]          hold_q;

  logic                 is_load;
  logic                 mem_ready_go;
  logic [31:0]          raw_data;
  logic [31:0]          ext_data;
  logic [DW-1:0]        wdata;

  // Handshake: a load can leave only once its data is here (held or arriving now).
  assign is_load      = (op_q != LOAD_NONE);
  assign mem_ready_go = !is_load || (state == M_HOLD) || data_sram_data_ok;
  assign o_mem_ready  = !mem_valid || (mem_ready_go && i_wb_ready);

  // Stage register and FSM. Accepting a new bundle always restarts the FSM, which
  // also covers leaving M_WAIT/M_HOLD; stray data_ok outside M_WAIT is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= M_IDLE;
      mem_valid <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      alu_q     <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      op_q      <= LOAD_NONE;
      hold_q    <= '0;
    end else begin
      if (o_mem_ready) begin
        mem_valid <= ex_to_mem_valid;
        state     <= (ex_to_mem_valid && (ex_to_mem_load_op != LOAD_NONE)) ? M_WAIT : M_IDLE;
      end else if ((state == M_WAIT) && data_sram_data_ok) begin
        state  <= M_HOLD;
        hold_q <= data_sram_rdata;
      end
      if (ex_to_mem_valid && o_mem_ready) begin
        pc_q    <= ex_to_mem_pc;
        inst_q  <= ex_to_mem_inst;
        alu_q   <= ex_to_mem_alu_result;
        waddr_q <= ex_to_mem_rf_waddr;
        we_q    <= ex_to_mem_rf_we;
        op_q    <= ex_to_mem_load_op;
      end
    end
  end

  assign raw_data = (state == M_HOLD) ? hold_q : data_sram_rdata;

  load_ext u_load_ext (
    .raw     (raw_data),
    .load_op (op_q),
    .addr    (alu_q[1:0]),
    .data    (ext_data)
  );

  assign wdata = is_load ? DW'(ext_data) : alu_q;

  assign mem_to_wb_valid    = mem_valid && mem_ready_go;
  assign mem_to_wb_rf_wdata = wdata;
  assign mem_to_wb_rf_waddr = mem_valid ? waddr_q : '0;
  assign mem_to_wb_rf_we    = mem_valid && we_q;
  assign mem_to_wb_pc       = pc_q;
  assign mem_to_wb_inst     = inst_q;
  assign mem_load_pending   = mem_valid && is_load && (state != M_HOLD) && !data_sram_data_ok;

`ifdef MEM_FWD_EN
  // Bypass only results that are final this cycle and target a real register.
  assign mem_fwd_valid = mem_valid && we_q && mem_ready_go && (waddr_q != '0);
  assign mem_fwd_waddr = waddr_q;
  assign mem_fwd_wdata = wdata;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_to_mem_valid = 1'b0;
  logic        o_mem_ready;
  logic [31:0] ex_to_mem_pc = '0;
  logic [31:0] ex_to_mem_inst = '0;
  logic [31:0] ex_to_mem_alu_result = '0;
  logic [4:0]  ex_to_mem_rf_waddr = '0;
  logic        ex_to_mem_rf_we = 1'b0;
  logic [2:0]  ex_to_mem_load_op = '0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        i_wb_ready = 1'b1;
  logic        mem_to_wb_valid;
  logic [31:0] mem_to_wb_rf_wdata;
  logic [4:0]  mem_to_wb_rf_waddr;
  logic        mem_to_wb_rf_we;
  logic [31:0] mem_to_wb_pc;
  logic [31:0] mem_to_wb_inst;
  logic        mem_load_pending;
`ifdef MEM_FWD_EN
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
`endif

  mem_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_to_mem_valid      (ex_to_mem_valid),
    .o_mem_ready          (o_mem_ready),
    .ex_to_mem_pc         (ex_to_mem_pc),
    .ex_to_mem_inst       (ex_to_mem_inst),
    .ex_to_mem_alu_result (ex_to_mem_alu_result),
    .ex_to_mem_rf_waddr   (ex_to_mem_rf_waddr),
    .ex_to_mem_rf_we      (ex_to_mem_rf_we),
    .ex_to_mem_load_op    (ex_to_mem_load_op),
    .data_sram_data_ok    (data_sram_data_ok),
    .data_sram_rdata      (data_sram_rdata),
    .i_wb_ready           (i_wb_ready),
    .mem_to_wb_valid      (mem_to_wb_valid),
    .mem_to_wb_rf_wdata   (mem_to_wb_rf_wdata),
    .mem_to_wb_rf_waddr   (mem_to_wb_rf_waddr),
    .mem_to_wb_rf_we      (mem_to_wb_rf_we),
    .mem_to_wb_pc         (mem_to_wb_pc),
    .mem_to_wb_inst       (mem_to_wb_inst),
    .mem_load_pending     (mem_load_pending)
`ifdef MEM_FWD_EN
    ,
    .mem_fwd_valid        (mem_fwd_valid),
    .mem_fwd_waddr        (mem_fwd_waddr),
    .mem_fwd_wdata        (mem_fwd_wdata)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_deliv = 0;

  // Transaction model: the instruction currently in MEM and whether its data arrived.
  logic        m_occ = 1'b0;
  logic [31:0] m_pc = '0, m_inst = '0, m_alu = '0, m_held = '0;
  logic [4:0]  m_waddr = '0;
  logic        m_we = 1'b0, m_got = 1'b0;
  logic [2:0]  m_op = '0;
  logic        e_ready, e_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected writeback value from the load-type rules, using shifts and masks.
  function automatic logic [31:0] exp_wdata(input logic [31:0] raw, input logic [2:0] op,
                                            input logic [31:0] alu);
    logic [31:0] b, h;
    b = (raw >> (int'(alu[1:0]) * 8)) & 32'h0000_00FF;
    h = (raw >> (int'(alu[1]) * 16)) & 32'h0000_FFFF;
    case (op)
      3'd0: return alu;
      3'd1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd5: return b;
      3'd2: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd6: return h;
      default: return raw;
    endcase
  endfunction

  // Compare every DUT output against the model, a little after inputs settle.
  task automatic cyc_begin();
    logic is_ld, have;
    logic [31:0] raw;
    #1;
    is_ld   = (m_op != 3'd0);
    have    = !is_ld || m_got || data_sram_data_ok;
    e_ready = !m_occ || (have && i_wb_ready);
    e_valid = m_occ && have;
    raw     = m_got ? m_held : data_sram_rdata;
    chk("mem_ready", 32'(o_mem_ready), 32'(e_ready));
    chk("wb_valid", 32'(mem_to_wb_valid), 32'(e_valid));
    chk("rf_we", 32'(mem_to_wb_rf_we), 32'(m_occ && m_we));
    chk("rf_waddr", 32'(mem_to_wb_rf_waddr), m_occ ? 32'(m_waddr) : 32'd0);
    chk("pc", mem_to_wb_pc, m_pc);
    chk("inst", mem_to_wb_inst, m_inst);
    chk("load_pending", 32'(mem_load_pending), 32'(m_occ && is_ld && !m_got && !data_sram_data_ok));
    if (e_valid) chk("wdata", mem_to_wb_rf_wdata, exp_wdata(raw, m_op, m_alu));
`ifdef MEM_FWD_EN
    chk("fwd_valid", 32'(mem_fwd_valid), 32'(e_valid && m_we && (m_waddr != 5'd0)));
    if (e_valid && m_we && (m_waddr != 5'd0)) begin
      chk("fwd_waddr", 32'(mem_fwd_waddr), 32'(m_waddr));
      chk("fwd_wdata", mem_fwd_wdata, exp_wdata(raw, m_op, m_alu));
    end
`endif
    if (mem_to_wb_valid && i_wb_ready) dut_deliv++;
  endtask

  // Advance one clock; model follows the same edge from the same inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_occ = 1'b0; m_pc = '0; m_inst = '0; m_alu = '0; m_waddr = '0;
      m_we = 1'b0; m_op = '0; m_got = 1'b0; m_held = '0;
    end else if (e_ready) begin
      m_occ = ex_to_mem_valid;
      m_got = 1'b0;
      if (ex_to_mem_valid) begin
        m_pc = ex_to_mem_pc; m_inst = ex_to_mem_inst; m_alu = ex_to_mem_alu_result;
        m_waddr = ex_to_mem_rf_waddr; m_we = ex_to_mem_rf_we; m_op = ex_to_mem_load_op;
      end
    end else if (m_occ && (m_op != 3'd0) && !m_got && data_sram_data_ok) begin
      m_got  = 1'b1;
      m_held = data_sram_rdata;
    end
    @(negedge clk);
  endtask

  task automatic set_ex(input logic v, input logic [2:0] op, input logic [31:0] alu,
                        input logic [4:0] waddr, input logic we);
    ex_to_mem_valid      = v;
    ex_to_mem_load_op    = op;
    ex_to_mem_alu_result = alu;
    ex_to_mem_rf_waddr   = waddr;
    ex_to_mem_rf_we      = we;
    ex_to_mem_pc         = $urandom;
    ex_to_mem_inst       = $urandom;
  endtask

  // Single load: accept, wait `dly` cycles without data, then data_ok with wb_ready=1.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                         input int dly, input logic [31:0] exp);
    i_wb_ready = 1'b1;
    data_sram_data_ok = 1'b0;
    set_ex(1'b1, op, addr, 5'd9, 1'b1);
    cyc_begin(); tick();
    set_ex(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
    for (int d = 0; d < dly; d++) begin
      cyc_begin();
      chk("ld_pending_wait", 32'(mem_load_pending), 32'd1);
      chk("ld_valid_wait", 32'(mem_to_wb_valid), 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    cyc_begin();
    chk("ld_valid_ok", 32'(mem_to_wb_valid), 32'd1);
    chk("ld_wdata", mem_to_wb_rf_wdata, exp);
    chk("ld_pending_ok", 32'(mem_load_pending), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    cyc_begin();
    chk("ld_after", 32'(mem_to_wb_valid), 32'd0);
    tick();
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc_begin();
    chk("rst_ready", 32'(o_mem_ready), 32'd1);
    chk("rst_valid", 32'(mem_to_wb_valid), 32'd0);
    chk("rst_wdata", mem_to_wb_rf_wdata, 32'd0);
    chk("rst_pc", mem_to_wb_pc, 32'd0);
    tick();

    // Reset while a load waits; the late response must be dropped.
    set_ex(1'b1, 3'd3, 32'h0000_0100, 5'd3, 1'b1);
    cyc_begin(); tick();
    set_ex(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
    cyc_begin();
    chk("wait_pending", 32'(mem_load_pending), 32'd1);
    tick();
    rst = 1'b0;
    cyc_begin(); tick();
    cyc_begin(); tick();
    rst = 1'b1;
    cyc_begin();
    chk("mid_rst_valid", 32'(mem_to_wb_valid), 32'd0);
    chk("mid_rst_ready", 32'(o_mem_ready), 32'd1);
    chk("mid_rst_we", 32'(mem_to_wb_rf_we), 32'd0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    cyc_begin();
    chk("stray_ok_valid", 32'(mem_to_wb_valid), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    cyc_begin();
    chk("stray_ok_after", 32'(mem_to_wb_valid), 32'd0);
    tick();

    // Back-to-back ALU stream, no bubbles.
    i_wb_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) set_ex(1'b1, 3'd0, 32'h11 * i, 5'(i), 1'b1);
      else        set_ex(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
      cyc_begin();
      chk("alu_ready", 32'(o_mem_ready), 32'd1);
      if (i >= 2) begin
        chk("alu_valid", 32'(mem_to_wb_valid), 32'd1);
        chk("alu_wdata", mem_to_wb_rf_wdata, 32'h11 * (i - 1));
        chk("alu_waddr", 32'(mem_to_wb_rf_waddr), 32'(i - 1));
      end
      tick();
    end
    cyc_begin(); tick();

    // Load extension.
    do_load(3'd1, 32'h0000_1003, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    do_load(3'd5, 32'h0000_1003, 32'h80FF_1234, 3, 32'h0000_0080);
    do_load(3'd6, 32'h0000_2002, 32'hBEEF_0001, 1, 32'h0000_BEEF);
    do_load(3'd2, 32'h0000_2002, 32'hBEEF_0001, 1, 32'hFFFF_BEEF);

    // WB stall with data arriving: held and delivered exactly once.
    set_ex(1'b1, 3'd3, 32'h0000_3000, 5'd12, 1'b1);
    cyc_begin(); tick();
    set_ex(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
    cyc_begin(); tick();
    dut_deliv = 0;
    i_wb_ready = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    cyc_begin();
    chk("stall_valid0", 32'(mem_to_wb_valid), 32'd1);
    chk("stall_ready0", 32'(o_mem_ready), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1234_5678;
    cyc_begin();
    chk("hold_valid", 32'(mem_to_wb_valid), 32'd1);
    chk("hold_ready", 32'(o_mem_ready), 32'd0);
    chk("hold_wdata", mem_to_wb_rf_wdata, 32'hCAFE_F00D);
    tick();
    i_wb_ready = 1'b1;
    cyc_begin();
    chk("release_wdata", mem_to_wb_rf_wdata, 32'hCAFE_F00D);
    tick();
    cyc_begin();
    chk("release_after", 32'(mem_to_wb_valid), 32'd0);
    tick();
    chk("deliver_once", 32'(dut_deliv), 32'd1);

`ifdef MEM_FWD_EN
    set_ex(1'b1, 3'd0, 32'h77, 5'd5, 1'b1);
    cyc_begin(); tick();
    set_ex(1'b1, 3'd0, 32'h99, 5'd0, 1'b1);
    cyc_begin();
    chk("fwd_r5_valid", 32'(mem_fwd_valid), 32'd1);
    chk("fwd_r5_waddr", 32'(mem_fwd_waddr), 32'd5);
    chk("fwd_r5_wdata", mem_fwd_wdata, 32'h77);
    tick();
    set_ex(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
    cyc_begin();
    chk("fwd_r0_valid", 32'(mem_fwd_valid), 32'd0);
    tick();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) != 0);
      set_ex($urandom_range(0, 9) < 7, ops[$urandom_range(0, 7)], $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      i_wb_ready = ($urandom_range(0, 3) != 0);
      data_sram_rdata = $urandom;
      data_sram_data_ok = m_occ && (m_op != 3'd0) && !m_got && ($urandom_range(0, 9) < 4);
      cyc_begin();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
